// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared constants and helpers for the LED PWM fader.
//   LED_COUNT        : number of LED channels driven by the fader
//   DEF_PWM_BITS     : default PWM counter width (frame = 2^PWM_BITS clocks)
//   DEF_STEP         : default duty change per fade step
//   DEF_FADE_FRAMES  : default number of PWM frames per fade step
//   fade_step()      : one saturating move of a duty value toward its target
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int LED_COUNT       = 8;
    localparam int DEF_PWM_BITS    = 8;
    localparam int DEF_STEP        = 8;
    localparam int DEF_FADE_FRAMES = 4;

    // Moves duty one step toward target and lands exactly on target when the
    // remaining distance is no larger than step. The arithmetic is done at
    // 32 bits, wider than any duty value, so the difference can never wrap
    // and the result can never overshoot the target.
    function automatic int unsigned fade_step(
        input int unsigned duty,
        input int unsigned target,
        input int unsigned step
    );
        int unsigned diff;
        if (duty < target) begin
            diff = target - duty;
            return (diff <= step) ? target : duty + step;
        end else if (duty > target) begin
            diff = duty - target;
            return (diff <= step) ? target : duty - step;
        end else begin
            return duty;
        end
    endfunction

endpackage

// File: rtl/led_pwm_fader_channel.sv
// -----------------------------------------------------------------------------
// led_fade_channel
// One LED channel: holds the duty and the sampled target, applies the jump or
// fade rule at each frame boundary, and produces the registered PWM bit.
//   clk, rst      : clock, synchronous active-high reset
//   i_fb          : frame boundary strobe (pwm counter at its maximum)
//   i_step        : fade step strobe (only meaningful together with i_fb)
//   i_fade_en     : 1 = ramp toward target, 0 = jump to target
//   i_on          : this LED's on/off bit from the pattern
//   i_brightness  : duty used when the LED is on
//   i_pwm_cnt     : shared free-running PWM counter
//   o_led         : registered PWM output
//   o_mismatch    : duty currently differs from the sampled target
// -----------------------------------------------------------------------------
module led_fade_channel
    import led_pkg::*;
#(
    parameter int          PWM_BITS = DEF_PWM_BITS,
    parameter int unsigned STEP     = DEF_STEP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_fb,
    input  logic                i_step,
    input  logic                i_fade_en,
    input  logic                i_on,
    input  logic [PWM_BITS-1:0] i_brightness,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led,
    output logic                o_mismatch
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] r_target;
    logic                r_led;
    logic [PWM_BITS-1:0] w_target_new;
    logic [PWM_BITS-1:0] w_duty_step;
    logic [PWM_BITS-1:0] w_duty_next;

    // Target is built from the pattern/brightness present at this boundary,
    // so a step taken at the same boundary already heads to the new target.
    assign w_target_new = i_on ? i_brightness : '0;
    assign w_duty_step  = PWM_BITS'(fade_step(32'(r_duty), 32'(w_target_new), STEP));

    always_comb begin
        w_duty_next = r_duty;
        if (i_fb) begin
            if (!i_fade_en) begin
                w_duty_next = w_target_new;
            end else if (i_step) begin
                w_duty_next = w_duty_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty   <= '0;
            r_target <= '0;
            r_led    <= 1'b0;
        end else begin
            r_duty <= w_duty_next;
            if (i_fb) begin
                r_target <= w_target_new;
            end
            // Full-scale duty is forced high so the LED is truly constant on;
            // the plain compare alone would leave one dark cycle per frame.
            r_led <= (r_duty == DUTY_MAX) || (i_pwm_cnt < r_duty);
        end
    end

    assign o_led      = r_led;
    assign o_mismatch = (r_duty != r_target);

endmodule

// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
// Drives 8 LEDs from the CPU core's on/off pattern with PWM brightness and
// per-LED fades between pattern changes.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   pattern     : LED on/off targets (sampled at the frame boundary)
//   brightness  : duty for LEDs that are on (sampled at the frame boundary)
//   fadeEn      : 1 = ramp toward target, 0 = jump to target
//   ledOut      : registered PWM LED drive
//   busy        : registered; some LED duty differs from its target
//   frameStart  : one-cycle pulse in the cycle where the PWM counter is 0
// -----------------------------------------------------------------------------
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int          PWM_BITS    = DEF_PWM_BITS,
    parameter int unsigned STEP        = DEF_STEP,
    parameter int          FADE_FRAMES = DEF_FADE_FRAMES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LED_COUNT-1:0] pattern,
    input  logic [PWM_BITS-1:0]  brightness,
    input  logic                 fadeEn,
    output logic [LED_COUNT-1:0] ledOut,
    output logic                 busy,
    output logic                 frameStart
);

    // A single-frame fade cadence still needs a one-bit counter to exist.
    localparam int               FC_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FADE_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    logic [PWM_BITS-1:0]  r_pwm_cnt;
    logic [FC_W-1:0]      r_frame_cnt;
    logic                 r_busy;
    logic                 r_frame_start;
    logic                 w_fb;
    logic                 w_step;
    logic [LED_COUNT-1:0] w_led;
    logic [LED_COUNT-1:0] w_mismatch;

    assign w_fb   = (r_pwm_cnt == PWM_MAX);
    assign w_step = w_fb && (r_frame_cnt == FC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_busy        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_fb) begin
                r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + FC_W'(1);
            end
            // The pulse is taken from the last count so it lines up with
            // the counter reading 0 in the following cycle.
            r_frame_start <= w_fb;
            r_busy        <= |w_mismatch;
        end
    end

    generate
        for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_chan
            led_fade_channel #(
                .PWM_BITS (PWM_BITS),
                .STEP     (STEP)
            ) u_chan (
                .clk          (clk),
                .rst          (rst),
                .i_fb         (w_fb),
                .i_step       (w_step),
                .i_fade_en    (fadeEn),
                .i_on         (pattern[gi]),
                .i_brightness (brightness),
                .i_pwm_cnt    (r_pwm_cnt),
                .o_led        (w_led[gi]),
                .o_mismatch   (w_mismatch[gi])
            );
        end
    endgenerate

    assign ledOut     = w_led;
    assign busy       = r_busy;
    assign frameStart = r_frame_start;

endmodule

// File: tb/tb_led_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_fader
// Scoreboard bench. Stimulus pushes, per measured PWM frame, the expected
// number of high ledOut cycles per LED and the expected mid-frame busy.
// A measured frame is the 256 ledOut samples from pwmCnt=1 up to and
// including the next frameStart cycle (ledOut lags pwmCnt by one cycle).
// Duty d gives d high samples, duty 255 gives 256 (constant on).
// -----------------------------------------------------------------------------
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pattern;
    logic [7:0] brightness;
    logic       fadeEn;
    logic [7:0] ledOut;
    logic       busy;
    logic       frameStart;

    always #5 clk = ~clk;

    led_pwm_fader #(
        .PWM_BITS    (8),
        .STEP        (8),
        .FADE_FRAMES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pattern    (pattern),
        .brightness (brightness),
        .fadeEn     (fadeEn),
        .ledOut     (ledOut),
        .busy       (busy),
        .frameStart (frameStart)
    );

    typedef struct packed {
        int         frame;
        logic [7:0] mask;
        logic [8:0] cnt;
        logic       bsy;
    } exp_t;

    exp_t q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   frame_no = 0;

    // LEDs in mask expect the given duty, all others expect duty 0.
    function automatic void push_exp(int f, logic [7:0] m, int duty, logic b);
        exp_t e;
        e.frame = f;
        e.mask  = m;
        e.cnt   = (duty == 255) ? 9'd256 : 9'(duty);
        e.bsy   = b;
        q.push_back(e);
    endfunction

    // Monitor: measures every frame, pops and checks due expectations.
    initial begin
        int   cnt [8];
        int   idx;
        int   exp_c;
        logic busy_mid;
        exp_t e;
        idx      = 0;
        busy_mid = 1'b0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                for (int i = 0; i < 8; i++) cnt[i] = 0;
                idx = 0;
            end else begin
                for (int i = 0; i < 8; i++) cnt[i] += int'(ledOut[i]);
                if (idx == 127) busy_mid = busy;
                idx++;
                if (frameStart === 1'b1) begin
                    while (q.size() > 0 && q[0].frame <= frame_no) begin
                        e = q.pop_front();
                        if (e.frame < frame_no) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL frame%0d missed: monitor at frame %0d, required check at %0d",
                                     e.frame, frame_no, e.frame);
                        end else begin
                            for (int i = 0; i < 8; i++) begin
                                exp_c = e.mask[i] ? int'(e.cnt) : 0;
                                n_tests++;
                                if (cnt[i] != exp_c) begin
                                    n_fail++;
                                    $display("FAIL frame%0d led%0d high count: got %0d required %0d",
                                             frame_no, i, cnt[i], exp_c);
                                end
                            end
                            n_tests++;
                            if (busy_mid !== e.bsy) begin
                                n_fail++;
                                $display("FAIL frame%0d busy: got %0b required %0b",
                                         frame_no, busy_mid, e.bsy);
                            end
                            $display("[TB] frame %0d: led0 high %0d/256, led7 high %0d/256, busy %0b",
                                     frame_no, cnt[0], cnt[7], busy_mid);
                        end
                    end
                    frame_no++;
                    for (int i = 0; i < 8; i++) cnt[i] = 0;
                    idx = 0;
                end
            end
        end
    end

    // Waits for the next frameStart; s is the index of the frame just measured.
    task automatic wfs(output int s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frameStart !== 1'b1 && n < 600);
        #1;
        if (frameStart !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL frameStart timeout: got none in %0d cycles, required within 256", n);
        end
        s = frame_no - 1;
    endtask

    task automatic drain();
        int s;
        int g;
        g = 0;
        while (q.size() > 0 && g < 60) begin
            wfs(s);
            g++;
        end
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset(input int ncyc, output int s);
        int n;
        rst = 1'b1;
        repeat (ncyc) begin
            @(negedge clk);
            n_tests += 3;
            if (ledOut !== 8'h00) begin
                n_fail++;
                $display("FAIL reset ledOut: got %h required 00", ledOut);
            end
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset busy: got %b required 0", busy);
            end
            if (frameStart !== 1'b0) begin
                n_fail++;
                $display("FAIL reset frameStart: got %b required 0", frameStart);
            end
        end
        #1;
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frameStart !== 1'b1 && n < 1000);
        n_tests++;
        if (n != 256) begin
            n_fail++;
            $display("FAIL first frameStart latency: got %0d cycles required 256", n);
        end
        $display("[TB] reset released, first frameStart after %0d cycles", n);
        #1;
        s = frame_no - 1;
    endtask

    task automatic zero_all();
        int s;
        wfs(s);
        fadeEn  = 1'b0;
        pattern = 8'h00;
        push_exp(s + 2, 8'h00, 0, 1'b0);
        drain();
    endtask

    initial begin
        int s;
        int t;
        int g;
        rst        = 1'b1;
        pattern    = 8'h00;
        brightness = 8'h00;
        fadeEn     = 1'b0;

        // Reset state and first frameStart.
        do_reset(3, s);

        // Fixed duty, no fade; change mid-frame affects only the next frame.
        repeat (100) @(negedge clk);
        #1;
        pattern    = 8'h01;
        brightness = 8'd128;
        push_exp(s + 1, 8'h00, 0,   1'b0);
        push_exp(s + 2, 8'h01, 128, 1'b0);
        push_exp(s + 3, 8'h01, 128, 1'b0);
        drain();

        // Fade up all LEDs to full scale in 8-steps, last step saturates.
        zero_all();
        wfs(s);
        fadeEn     = 1'b1;
        brightness = 8'd255;
        pattern    = 8'hFF;
        push_exp(s + 1, 8'hFF, 0, 1'b0);
        for (int k = 1; k <= 32; k++)
            push_exp(s + 1 + k, 8'hFF, (k < 32) ? 8 * k : 255, (k < 32));
        push_exp(s + 34, 8'hFF, 255, 1'b0);
        drain();

        // Saturation at a non-multiple target.
        zero_all();
        wfs(s);
        fadeEn     = 1'b1;
        brightness = 8'd20;
        pattern    = 8'h01;
        push_exp(s + 1, 8'h01, 0,  1'b0);
        push_exp(s + 2, 8'h01, 8,  1'b1);
        push_exp(s + 3, 8'h01, 16, 1'b1);
        push_exp(s + 4, 8'h01, 20, 1'b0);
        push_exp(s + 5, 8'h01, 20, 1'b0);
        drain();

        // Reversal mid-fade at duty 64.
        zero_all();
        wfs(s);
        t          = s;
        fadeEn     = 1'b1;
        brightness = 8'd255;
        pattern    = 8'h01;
        push_exp(t + 1, 8'h01, 0, 1'b0);
        for (int k = 1; k <= 8; k++) push_exp(t + 1 + k, 8'h01, 8 * k, 1'b1);
        for (int i = 0; i < 8; i++) wfs(s);
        pattern = 8'h00;
        for (int j = 0; j < 8; j++) push_exp(s + 2 + j, 8'h01, 56 - 8 * j, (j < 7));
        push_exp(s + 10, 8'h01, 0, 1'b0);
        drain();

        // Reset mid-fade at duty 100.
        zero_all();
        wfs(s);
        t          = s;
        fadeEn     = 1'b0;
        brightness = 8'd4;
        pattern    = 8'h01;
        push_exp(t + 1, 8'h01, 0, 1'b0);
        push_exp(t + 2, 8'h01, 4, 1'b0);
        wfs(s);
        fadeEn     = 1'b1;
        brightness = 8'd255;
        for (int k = 1; k <= 11; k++) push_exp(t + 2 + k, 8'h01, 4 + 8 * k, 1'b1);
        g = 0;
        while (s < t + 13 && g < 40) begin
            wfs(s);
            g++;
        end
        repeat (50) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy before mid-fade reset: got %b required 1", busy);
        end
        #1;
        do_reset(3, s);
        push_exp(s + 1, 8'h01, 8,  1'b1);
        push_exp(s + 2, 8'h01, 16, 1'b1);
        push_exp(s + 3, 8'h01, 24, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
